// File: rtl/lcd_size_pkg.sv
// Shared constants, geometry record and FSM encoding for the LCD size
// configuration controller.
package lcd_size_pkg;

  localparam logic [15:0] ID_4342 = 16'h4342;
  localparam logic [15:0] ID_7084 = 16'h7084;
  localparam logic [15:0] ID_7016 = 16'h7016;
  localparam logic [15:0] ID_1018 = 16'h1018;

  localparam logic [15:0] REG_W_HI = 16'h3808;
  localparam logic [15:0] REG_W_LO = 16'h3809;
  localparam logic [15:0] REG_H_HI = 16'h380A;
  localparam logic [15:0] REG_H_LO = 16'h380B;
  localparam logic [15:0] REG_HT_HI = 16'h380C;
  localparam logic [15:0] REG_HT_LO = 16'h380D;
  localparam logic [15:0] REG_VT_HI = 16'h380E;
  localparam logic [15:0] REG_VT_LO = 16'h380F;

  typedef struct packed {
    logic [12:0] w;
    logic [12:0] h;
    logic [12:0] hts;
    logic [12:0] vts;
  } geom_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  // Returns {addr, data} for one entry of the sensor write table.
  function automatic logic [23:0] wr_entry(
    input logic [2:0] idx,
    input geom_t      g
  );
    logic [23:0] e;
    unique case (idx)
      3'd0: e = {REG_W_HI, 3'b0, g.w[12:8]};
      3'd1: e = {REG_W_LO, g.w[7:0]};
      3'd2: e = {REG_H_HI, 3'b0, g.h[12:8]};
      3'd3: e = {REG_H_LO, g.h[7:0]};
      3'd4: e = {REG_HT_HI, 3'b0, g.hts[12:8]};
      3'd5: e = {REG_HT_LO, g.hts[7:0]};
      3'd6: e = {REG_VT_HI, 3'b0, g.vts[12:8]};
      3'd7: e = {REG_VT_LO, g.vts[7:0]};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/lcd_size_cfg_ctrl_if.sv
// SCCB write-request handshake between the size controller (master)
// and the SCCB bus engine (slave).
interface lcd_size_cfg_ctrl_if;

  logic        sccb_req;
  logic [15:0] sccb_addr;
  logic [7:0]  sccb_data;
  logic        sccb_ack;
  logic        sccb_done;
  logic        sccb_err;

  modport master (
    output sccb_req, sccb_addr, sccb_data,
    input  sccb_ack, sccb_done, sccb_err
  );

  modport slave (
    input  sccb_req, sccb_addr, sccb_data,
    output sccb_ack, sccb_done, sccb_err
  );

endinterface

// File: rtl/lcd_geom_lut.sv
// Combinational LCD ID -> geometry lookup plus active-area product.
// Unknown IDs fall back to the 800x480 panel.
import lcd_size_pkg::*;

module lcd_geom_lut (
  input  logic [15:0] i_id,
  output geom_t       o_geom,
  output logic [23:0] o_area
);

  always_comb begin
    o_geom = '{13'd800, 13'd480, 13'd1800, 13'd1000};
    case (i_id)
      ID_4342: o_geom = '{13'd480, 13'd272, 13'd1800, 13'd1000};
      ID_7084: o_geom = '{13'd800, 13'd480, 13'd1800, 13'd1000};
      ID_7016: o_geom = '{13'd1024, 13'd600, 13'd2200, 13'd1000};
      ID_1018: o_geom = '{13'd1280, 13'd800, 13'd2570, 13'd980};
      default: o_geom = '{13'd800, 13'd480, 13'd1800, 13'd1000};
    endcase
  end

  assign o_area = 24'(o_geom.w) * 24'(o_geom.h);

endmodule

// File: rtl/lcd_size_cfg_ctrl.sv
// Debounces ID_lcd, publishes panel geometry and programs the sensor size.
// LCD_SIZE_CFG_TIMING_EN adds the HTS/VTS writes (8-entry table).
import lcd_size_pkg::*;

module lcd_size_cfg_ctrl #(
  parameter int STABLE_CYC = 1024,
  parameter int MAX_RETRY  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [15:0]                ID_lcd,
  lcd_size_cfg_ctrl_if.master        sccb,
  output logic [12:0]                cmos_h_pixel,
  output logic [12:0]                cmos_v_pixel,
  output logic [12:0]                total_h_pixel,
  output logic [12:0]                total_v_pixel,
  output logic [23:0]                sdram_max_addr,
  output logic                       cfg_done,
  output logic                       cfg_err
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
`ifdef LCD_SIZE_CFG_TIMING_EN
  localparam logic [2:0] LAST_IDX = 3'd7;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif

  logic [15:0]   r_id_prev;
  logic [CW-1:0] r_stab_cnt;
  logic [15:0]   r_active;
  logic          r_act_vld;
  logic          r_pend;
  logic [15:0]   r_pend_id;
  state_t        r_state;
  logic [2:0]    r_idx;
  logic [RW-1:0] r_retry;
  logic          r_req;
  logic          r_early;
  logic          r_early_err;
  geom_t         r_geom;
  logic [23:0]   r_area;
  logic          r_done;
  logic          r_err;

  geom_t         w_geom;
  logic [23:0]   w_area;
  logic [23:0]   w_entry;
  logic          w_stable;
  logic          w_new_id;
  logic          w_busy;
  logic          w_done;
  logic          w_err;

  lcd_geom_lut u_lut (
    .i_id   (r_active),
    .o_geom (w_geom),
    .o_area (w_area)
  );

  assign w_stable = (r_stab_cnt == CW'(STABLE_CYC));
  assign w_new_id = w_stable &&
                    (!r_act_vld || r_id_prev != r_active);
  assign w_busy   = (r_state == S_REQ) || (r_state == S_WAIT);
  // A done seen together with ack in S_REQ is replayed in S_WAIT.
  assign w_done   = sccb.sccb_done || r_early;
  assign w_err    = r_early ? r_early_err : sccb.sccb_err;
  assign w_entry  = wr_entry(r_idx, r_geom);

  assign sccb.sccb_req  = r_req;
  assign sccb.sccb_addr = r_req ? w_entry[23:8] : 16'h0;
  assign sccb.sccb_data = r_req ? w_entry[7:0] : 8'h0;

  assign cmos_h_pixel   = r_geom.w;
  assign cmos_v_pixel   = r_geom.h;
  assign total_h_pixel  = r_geom.hts;
  assign total_v_pixel  = r_geom.vts;
  assign sdram_max_addr = r_area;
  assign cfg_done       = r_done;
  assign cfg_err        = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_prev  <= '0;
      r_stab_cnt <= '0;
    end else begin
      r_id_prev <= ID_lcd;
      if (ID_lcd != r_id_prev)
        r_stab_cnt <= '0;
      else if (!w_stable)
        r_stab_cnt <= r_stab_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_active    <= '0;
      r_act_vld   <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_id   <= '0;
      r_idx       <= '0;
      r_retry     <= '0;
      r_req       <= 1'b0;
      r_early     <= 1'b0;
      r_early_err <= 1'b0;
      r_geom      <= '0;
      r_area      <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_busy && w_new_id) begin
        r_pend    <= 1'b1;
        r_pend_id <= r_id_prev;
      end else if (w_busy && w_stable) begin
        r_pend <= 1'b0;
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_new_id) begin
            r_active  <= r_id_prev;
            r_act_vld <= 1'b1;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_geom  <= w_geom;
          r_area  <= w_area;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_idx   <= '0;
          r_retry <= '0;
          r_pend  <= 1'b0;
          r_req   <= 1'b1;
          r_state <= S_REQ;
        end
        S_REQ: begin
          if (sccb.sccb_ack) begin
            r_req       <= 1'b0;
            r_early     <= sccb.sccb_done;
            r_early_err <= sccb.sccb_err;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_done) begin
            r_early <= 1'b0;
            if (r_pend) begin
              r_active <= r_pend_id;
              r_state  <= S_LOAD;
            end else if (!w_err) begin
              if (r_idx == LAST_IDX) begin
                r_state <= S_DONE;
              end else begin
                r_idx   <= r_idx + 3'd1;
                r_retry <= '0;
                r_req   <= 1'b1;
                r_state <= S_REQ;
              end
            end else if (r_retry < RW'(MAX_RETRY)) begin
              r_retry <= r_retry + RW'(1);
              r_req   <= 1'b1;
              r_state <= S_REQ;
            end else begin
              r_state <= S_ERR;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        S_ERR: begin
          r_err   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_size_cfg_ctrl.sv
// Directed bench for lcd_size_cfg_ctrl with a scripted SCCB responder.
// Honours LCD_SIZE_CFG_TIMING_EN for the expected write count.
module tb_lcd_size_cfg_ctrl;

`ifdef LCD_SIZE_CFG_TIMING_EN
  localparam int N_WR = 8;
`else
  localparam int N_WR = 4;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] ID_lcd;
  logic [12:0] cmos_h_pixel;
  logic [12:0] cmos_v_pixel;
  logic [12:0] total_h_pixel;
  logic [12:0] total_v_pixel;
  logic [23:0] sdram_max_addr;
  logic        cfg_done;
  logic        cfg_err;

  lcd_size_cfg_ctrl_if sif ();

  lcd_size_cfg_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .ID_lcd         (ID_lcd),
    .sccb           (sif),
    .cmos_h_pixel   (cmos_h_pixel),
    .cmos_v_pixel   (cmos_v_pixel),
    .total_h_pixel  (total_h_pixel),
    .total_v_pixel  (total_v_pixel),
    .sdram_max_addr (sdram_max_addr),
    .cfg_done       (cfg_done),
    .cfg_err        (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // responder knobs
  bit          m_en = 1'b1;
  bit          m_fused = 1'b0;
  int          done_dly = 10;
  logic [15:0] slow_addr = 16'h0;
  int          slow_dly = 10;
  logic [15:0] err_addr = 16'h0;
  int          err_limit = 0;
  int          err_used = 0;

  logic [15:0] wr_addr [0:255];
  logic [7:0]  wr_data [0:255];
  int          n_wr = 0;

  initial begin : responder
    logic [15:0] a;
    int d;
    sif.sccb_ack  = 1'b0;
    sif.sccb_done = 1'b0;
    sif.sccb_err  = 1'b0;
    forever begin
      @(negedge clk);
      if (m_en && !rst && sif.sccb_req === 1'b1) begin
        a = sif.sccb_addr;
        if (n_wr < 256) begin
          wr_addr[n_wr] = a;
          wr_data[n_wr] = sif.sccb_data;
        end
        n_wr++;
        @(negedge clk);
        sif.sccb_ack = 1'b1;
        if (m_fused) sif.sccb_done = 1'b1;
        @(negedge clk);
        sif.sccb_ack  = 1'b0;
        sif.sccb_done = 1'b0;
        if (!m_fused) begin
          d = (a == slow_addr) ? slow_dly : done_dly;
          repeat (d - 1) @(negedge clk);
          sif.sccb_done = 1'b1;
          if (a == err_addr && err_used < err_limit) begin
            sif.sccb_err = 1'b1;
            err_used++;
          end
          @(negedge clk);
          sif.sccb_done = 1'b0;
          sif.sccb_err  = 1'b0;
        end
      end
    end
  end

  task automatic do_reset(input logic [15:0] id);
    ID_lcd = id;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_cfg(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk);
      #1;
      if (cfg_done || cfg_err) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    ID_lcd = 16'h7084;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({sif.sccb_req, sif.sccb_addr, sif.sccb_data,
         cmos_h_pixel, cmos_v_pixel, total_h_pixel, total_v_pixel,
         sdram_max_addr, cfg_done, cfg_err} !== '0)
      $display("FAIL reset_outputs got req=%b w=%0d addr=%h done=%b",
               sif.sccb_req, cmos_h_pixel, sif.sccb_addr, cfg_done);
    else n_pass++;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_chk++;
    if ({sif.sccb_req, cmos_h_pixel, cfg_done} !== '0)
      $display("FAIL reset_pre_stable got req=%b w=%0d done=%b want 0",
               sif.sccb_req, cmos_h_pixel, cfg_done);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [15:0] ea [4] = '{16'h3808, 16'h3809, 16'h380A, 16'h380B};
    logic [7:0]  ed [4] = '{8'h03, 8'h20, 8'h01, 8'hE0};
    int b;
    bit ok;
    b = n_wr - 2;
    b = (b < 0) ? 0 : b;
    b = 0;
    wait_cfg(3000, ok);
    n_chk++;
    if (!ok || cfg_done !== 1'b1)
      $display("FAIL basic_done got %b want 1", cfg_done);
    else n_pass++;
    n_chk++;
    if ({cmos_h_pixel, cmos_v_pixel, total_h_pixel, total_v_pixel}
        !== {13'd800, 13'd480, 13'd1800, 13'd1000})
      $display("FAIL basic_geom got %0d %0d %0d %0d want 800 480 1800 1000",
               cmos_h_pixel, cmos_v_pixel, total_h_pixel, total_v_pixel);
    else n_pass++;
    n_chk++;
    if (sdram_max_addr !== 24'd384000)
      $display("FAIL basic_area got %0d want 384000", sdram_max_addr);
    else n_pass++;
    n_chk++;
    if (n_wr - b !== N_WR)
      $display("FAIL basic_nwr got %0d want %0d", n_wr - b, N_WR);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if ({wr_addr[b+k], wr_data[b+k]} !== {ea[k], ed[k]})
        $display("FAIL basic_wr%0d got %h=%h want %h=%h", k,
                 wr_addr[b+k], wr_data[b+k], ea[k], ed[k]);
      else n_pass++;
    end
  endtask

  task automatic test_debounce();
    int b;
    bit ok;
    do_reset(16'h4342);
    b = n_wr;
    for (int i = 0; i < 8; i++) begin
      ID_lcd = (i % 2 == 0) ? 16'h4342 : 16'h1018;
      repeat (500) @(posedge clk);
      #1;
    end
    n_chk++;
    if (n_wr !== b || cmos_h_pixel !== 13'd0 || sdram_max_addr !== 24'd0)
      $display("FAIL toggle_quiet got nwr=%0d w=%0d area=%0d want 0",
               n_wr - b, cmos_h_pixel, sdram_max_addr);
    else n_pass++;
    wait_cfg(2000, ok);
    n_chk++;
    if (!ok || cfg_done !== 1'b1)
      $display("FAIL toggle_done got %b want 1", cfg_done);
    else n_pass++;
    n_chk++;
    if ({cmos_h_pixel, cmos_v_pixel, total_h_pixel, total_v_pixel}
        !== {13'd1280, 13'd800, 13'd2570, 13'd980})
      $display("FAIL toggle_geom got %0d %0d %0d %0d want 1280 800 2570 980",
               cmos_h_pixel, cmos_v_pixel, total_h_pixel, total_v_pixel);
    else n_pass++;
    n_chk++;
    if (sdram_max_addr !== 24'd1024000)
      $display("FAIL toggle_area got %0d want 1024000", sdram_max_addr);
    else n_pass++;
`ifdef LCD_SIZE_CFG_TIMING_EN
    begin
      logic [15:0] ta [4] = '{16'h380C, 16'h380D, 16'h380E, 16'h380F};
      logic [7:0]  td [4] = '{8'h0A, 8'h0A, 8'h03, 8'hD4};
      for (int k = 0; k < 4; k++) begin
        n_chk++;
        if ({wr_addr[b+4+k], wr_data[b+4+k]} !== {ta[k], td[k]})
          $display("FAIL timing_wr%0d got %h=%h want %h=%h", k + 4,
                   wr_addr[b+4+k], wr_data[b+4+k], ta[k], td[k]);
        else n_pass++;
      end
    end
`endif
  endtask

  task automatic test_restart();
    int b;
    int seen_done;
    bit ok;
    do_reset(16'h4342);
    b = n_wr;
    slow_addr = 16'h380A;
    slow_dly = 1300;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (n_wr - b >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    ID_lcd = 16'h7016;
    seen_done = 0;
    for (int i = 0; i < 3000 && ok; i++) begin
      @(posedge clk);
      #1;
      if (cfg_done) seen_done++;
      if (n_wr - b >= 4) break;
    end
    slow_addr = 16'h0;
    n_chk++;
    if (n_wr - b < 4 || seen_done != 0)
      $display("FAIL restart_pending got nwr=%0d done_cycles=%0d want 4 0",
               n_wr - b, seen_done);
    else n_pass++;
    n_chk++;
    if ({wr_addr[b+2], wr_data[b+2]} !== {16'h380A, 8'h01})
      $display("FAIL restart_wr2 got %h=%h want 380a=01",
               wr_addr[b+2], wr_data[b+2]);
    else n_pass++;
    n_chk++;
    if ({wr_addr[b+3], wr_data[b+3]} !== {16'h3808, 8'h04})
      $display("FAIL restart_first got %h=%h want 3808=04",
               wr_addr[b+3], wr_data[b+3]);
    else n_pass++;
    wait_cfg(3000, ok);
    n_chk++;
    if (!ok || cfg_done !== 1'b1 || n_wr - b !== N_WR + 3)
      $display("FAIL restart_done got done=%b nwr=%0d want 1 %0d",
               cfg_done, n_wr - b, N_WR + 3);
    else n_pass++;
    n_chk++;
    if ({cmos_h_pixel, cmos_v_pixel, sdram_max_addr}
        !== {13'd1024, 13'd600, 24'd614400})
      $display("FAIL restart_geom got %0d %0d %0d want 1024 600 614400",
               cmos_h_pixel, cmos_v_pixel, sdram_max_addr);
    else n_pass++;
  endtask

  task automatic test_retry();
    int b;
    int n9;
    bit ok;
    do_reset(16'h7084);
    b = n_wr;
    err_addr = 16'h3809;
    err_limit = err_used + 3;
    wait_cfg(3000, ok);
    n9 = 0;
    for (int k = 0; k < 16; k++)
      if (b + k < n_wr && wr_addr[b+k] == 16'h3809) n9++;
    n_chk++;
    if (!ok || cfg_done !== 1'b1 || cfg_err !== 1'b0)
      $display("FAIL retry_ok got done=%b err=%b want 1 0", cfg_done, cfg_err);
    else n_pass++;
    n_chk++;
    if (n9 != 4 || n_wr - b !== N_WR + 3)
      $display("FAIL retry_count got n3809=%0d nwr=%0d want 4 %0d",
               n9, n_wr - b, N_WR + 3);
    else n_pass++;
    do_reset(16'h7084);
    b = n_wr;
    err_limit = err_used + 4;
    wait_cfg(3000, ok);
    n_chk++;
    if (!ok || cfg_err !== 1'b1 || cfg_done !== 1'b0)
      $display("FAIL retry_exhaust got done=%b err=%b want 0 1",
               cfg_done, cfg_err);
    else n_pass++;
    repeat (200) @(posedge clk);
    #1;
    n_chk++;
    if (n_wr - b !== 5 || sif.sccb_req !== 1'b0)
      $display("FAIL retry_quiet got nwr=%0d req=%b want 5 0",
               n_wr - b, sif.sccb_req);
    else n_pass++;
    err_addr = 16'h0;
  endtask

  task automatic test_reset_mid();
    int b;
    bit ok;
    m_en = 1'b0;
    do_reset(16'h0000);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (sif.sccb_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!ok || cmos_h_pixel !== 13'd800)
      $display("FAIL midrst_pre got req=%b w=%0d want 1 800",
               sif.sccb_req, cmos_h_pixel);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_chk++;
    if ({sif.sccb_req, sif.sccb_addr, sif.sccb_data,
         cmos_h_pixel, cmos_v_pixel, total_h_pixel, total_v_pixel,
         sdram_max_addr, cfg_done, cfg_err} !== '0)
      $display("FAIL midrst_zero got req=%b w=%0d area=%0d want 0",
               sif.sccb_req, cmos_h_pixel, sdram_max_addr);
    else n_pass++;
    rst = 1'b0;
    m_en = 1'b1;
    b = n_wr;
    wait_cfg(3000, ok);
    n_chk++;
    if (!ok || cfg_done !== 1'b1 || n_wr - b !== N_WR)
      $display("FAIL midrst_reconf got done=%b nwr=%0d want 1 %0d",
               cfg_done, n_wr - b, N_WR);
    else n_pass++;
    n_chk++;
    if ({cmos_h_pixel, cmos_v_pixel, wr_data[b+1]}
        !== {13'd800, 13'd480, 8'h20})
      $display("FAIL midrst_geom got %0d %0d %h want 800 480 20",
               cmos_h_pixel, cmos_v_pixel, wr_data[b+1]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] ea [4] = '{16'h3808, 16'h3809, 16'h380A, 16'h380B};
    logic [7:0]  ed [4] = '{8'h05, 8'h00, 8'h03, 8'h20};
    int b;
    bit ok;
    m_fused = 1'b1;
    do_reset(16'h1018);
    b = n_wr;
    wait_cfg(3000, ok);
    n_chk++;
    if (!ok || cfg_done !== 1'b1 || n_wr - b !== N_WR)
      $display("FAIL fused_done got done=%b nwr=%0d want 1 %0d",
               cfg_done, n_wr - b, N_WR);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if ({wr_addr[b+k], wr_data[b+k]} !== {ea[k], ed[k]})
        $display("FAIL fused_wr%0d got %h=%h want %h=%h", k,
                 wr_addr[b+k], wr_data[b+k], ea[k], ed[k]);
      else n_pass++;
    end
    m_fused = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ID_lcd = 16'h0;
    test_reset();
    test_basic();
    test_debounce();
    test_restart();
    test_retry();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
